// File: rtl/i2s_codec_bridge.sv
// i2s_codec_bridge: WM8731 slave-mode I2S pins <-> left/right Avalon-ST sample streams.
// Optional macro I2S_CODEC_BRIDGE_LOOPBACK_EN adds i_loopback (ADC samples replayed on DAC).
module i2s_codec_bridge #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_aud_bclk,
  input  logic              i_aud_adclrck,
  input  logic              i_aud_adcdat,
  input  logic              i_aud_daclrck,
  output logic              o_aud_dacdat,
  output logic [DATA_W-1:0] adc_left_data,
  output logic              adc_left_valid,
  input  logic              adc_left_ready,
  output logic [DATA_W-1:0] adc_right_data,
  output logic              adc_right_valid,
  input  logic              adc_right_ready,
  input  logic [DATA_W-1:0] dac_left_data,
  input  logic              dac_left_valid,
  output logic              dac_left_ready,
  input  logic [DATA_W-1:0] dac_right_data,
  input  logic              dac_right_valid,
  output logic              dac_right_ready,
`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
  input  logic              i_loopback,
`endif
  input  logic              i_clr_status,
  output logic              o_adc_overrun,
  output logic              o_dac_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [SYNC_STAGES-1:0] bclk_sync, adclrck_sync, adcdat_sync, daclrck_sync;
  logic bclk_s, adclrck_s, adcdat_s, daclrck_s, bclk_prev;
  logic bclk_rise, bclk_fall;

  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  rx_cnt;
  logic rx_ch, rx_lr_prev, rx_hist, rx_armed, cap;
  logic overrun_evt;

  logic [DATA_W-1:0] sink_l, sink_r, tx_shift, load_word;
  logic sink_l_full, sink_r_full;
  logic [CNT_W-1:0]  tx_cnt;
  logic tx_lr_prev, tx_hist, dac_load, load_left, load_right, underrun_evt, loop_on;

`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
  assign loop_on = i_loopback;
`else
  assign loop_on = 1'b0;
`endif

  // All four pins share the same depth so LRCK/DATA keep their alignment to BCLK.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync    <= '0;
      adclrck_sync <= '0;
      adcdat_sync  <= '0;
      daclrck_sync <= '0;
      bclk_prev    <= 1'b0;
    end else begin
      bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], i_aud_bclk};
      adclrck_sync <= {adclrck_sync[SYNC_STAGES-2:0], i_aud_adclrck};
      adcdat_sync  <= {adcdat_sync[SYNC_STAGES-2:0], i_aud_adcdat};
      daclrck_sync <= {daclrck_sync[SYNC_STAGES-2:0], i_aud_daclrck};
      bclk_prev    <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign adclrck_s = adclrck_sync[SYNC_STAGES-1];
  assign adcdat_s  = adcdat_sync[SYNC_STAGES-1];
  assign daclrck_s = daclrck_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;
  assign bclk_fall = ~bclk_s & bclk_prev;

  // The first edge after reset only records LRCK; capture arms at the first real transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_shift   <= '0;
      rx_cnt     <= '0;
      rx_ch      <= 1'b0;
      rx_lr_prev <= 1'b0;
      rx_hist    <= 1'b0;
      rx_armed   <= 1'b0;
      cap        <= 1'b0;
    end else begin
      cap <= 1'b0;
      if (bclk_rise) begin
        rx_hist    <= 1'b1;
        rx_lr_prev <= adclrck_s;
        if (rx_hist && (adclrck_s != rx_lr_prev)) begin
          rx_cnt   <= '0;
          rx_ch    <= adclrck_s;
          rx_armed <= 1'b1;
        end else if (rx_armed && (rx_cnt < CNT_FULL)) begin
          rx_shift <= {rx_shift[DATA_W-2:0], adcdat_s};
          rx_cnt   <= rx_cnt + CNT_W'(1);
          cap      <= (rx_cnt == CNT_FULL - CNT_W'(1));
        end
      end
    end
  end

  // Streams: a beat transfers on a cycle with valid && ready; valid and data hold until then.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adc_left_data  <= '0;
      adc_left_valid <= 1'b0;
    end else if (cap && !rx_ch) begin
      adc_left_data  <= rx_shift;
      adc_left_valid <= 1'b1;
    end else if (adc_left_valid && adc_left_ready) begin
      adc_left_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adc_right_data  <= '0;
      adc_right_valid <= 1'b0;
    end else if (cap && rx_ch) begin
      adc_right_data  <= rx_shift;
      adc_right_valid <= 1'b1;
    end else if (adc_right_valid && adc_right_ready) begin
      adc_right_valid <= 1'b0;
    end
  end

  assign overrun_evt = cap && (rx_ch ? (adc_right_valid && !adc_right_ready)
                                     : (adc_left_valid && !adc_left_ready));

  assign dac_load   = bclk_fall && tx_hist && (daclrck_s != tx_lr_prev);
  assign load_left  = dac_load && !daclrck_s && !loop_on;
  assign load_right = dac_load && daclrck_s && !loop_on;

  always_comb begin
    load_word    = '0;
    underrun_evt = 1'b0;
    if (loop_on) begin
      load_word = daclrck_s ? adc_right_data : adc_left_data;
    end else if (daclrck_s) begin
      load_word    = sink_r_full ? sink_r : '0;
      underrun_evt = dac_load && !sink_r_full;
    end else begin
      load_word    = sink_l_full ? sink_l : '0;
      underrun_evt = dac_load && !sink_l_full;
    end
  end

  // An accept in the load cycle comes last, so the buffer ends full with the new sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sink_l      <= '0;
      sink_l_full <= 1'b0;
      sink_r      <= '0;
      sink_r_full <= 1'b0;
    end else begin
      if (load_left)  sink_l_full <= 1'b0;
      if (load_right) sink_r_full <= 1'b0;
      if (dac_left_valid && !sink_l_full) begin
        sink_l      <= dac_left_data;
        sink_l_full <= 1'b1;
      end
      if (dac_right_valid && !sink_r_full) begin
        sink_r      <= dac_right_data;
        sink_r_full <= 1'b1;
      end
    end
  end

  assign dac_left_ready  = ~sink_l_full;
  assign dac_right_ready = ~sink_r_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_lr_prev   <= 1'b0;
      tx_hist      <= 1'b0;
      o_aud_dacdat <= 1'b0;
    end else if (bclk_fall) begin
      tx_hist    <= 1'b1;
      tx_lr_prev <= daclrck_s;
      if (dac_load) begin
        tx_shift <= load_word;
        tx_cnt   <= '0;
      end else if (tx_cnt < CNT_FULL) begin
        o_aud_dacdat <= tx_shift[DATA_W-1];
        tx_shift     <= {tx_shift[DATA_W-2:0], 1'b0};
        tx_cnt       <= tx_cnt + CNT_W'(1);
      end else begin
        o_aud_dacdat <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_adc_overrun  <= 1'b0;
      o_dac_underrun <= 1'b0;
    end else begin
      if (overrun_evt)       o_adc_overrun <= 1'b1;
      else if (i_clr_status) o_adc_overrun <= 1'b0;
      if (underrun_evt)      o_dac_underrun <= 1'b1;
      else if (i_clr_status) o_dac_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_codec_bridge.sv
// Directed bench for i2s_codec_bridge: codec model at BCLK = i_clk/8, 32 BCLK per LRCK half.
module tb_i2s_codec_bridge;
  localparam int DW = 16;

  logic i_clk, i_rst;
  logic i_aud_bclk, i_aud_adclrck, i_aud_adcdat, i_aud_daclrck, o_aud_dacdat;
  logic [DW-1:0] adc_left_data, adc_right_data, dac_left_data, dac_right_data;
  logic adc_left_valid, adc_left_ready, adc_right_valid, adc_right_ready;
  logic dac_left_valid, dac_left_ready, dac_right_valid, dac_right_ready;
  logic i_clr_status, o_adc_overrun, o_dac_underrun;
`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
  logic i_loopback;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int lcnt = 0;
  int rcnt = 0;
  logic [DW-1:0] llast = '0;
  logic [DW-1:0] rlast = '0;

  i2s_codec_bridge #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_aud_bclk(i_aud_bclk), .i_aud_adclrck(i_aud_adclrck), .i_aud_adcdat(i_aud_adcdat),
    .i_aud_daclrck(i_aud_daclrck), .o_aud_dacdat(o_aud_dacdat),
    .adc_left_data(adc_left_data), .adc_left_valid(adc_left_valid), .adc_left_ready(adc_left_ready),
    .adc_right_data(adc_right_data), .adc_right_valid(adc_right_valid), .adc_right_ready(adc_right_ready),
    .dac_left_data(dac_left_data), .dac_left_valid(dac_left_valid), .dac_left_ready(dac_left_ready),
    .dac_right_data(dac_right_data), .dac_right_valid(dac_right_valid), .dac_right_ready(dac_right_ready),
`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
    .i_loopback(i_loopback),
`endif
    .i_clr_status(i_clr_status), .o_adc_overrun(o_adc_overrun), .o_dac_underrun(o_dac_underrun)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Accepted ADC beats, observed mid-cycle ahead of the edge that transfers them
  always @(negedge i_clk) begin
    if (adc_left_valid && adc_left_ready) begin
      lcnt  <= lcnt + 1;
      llast <= adc_left_data;
    end
    if (adc_right_valid && adc_right_ready) begin
      rcnt  <= rcnt + 1;
      rlast <= adc_right_data;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // One BCLK period: falling edge with new LRCK/data, rising edge, DACDAT sampled at the end.
  task automatic slot(input logic lr, input logic bit_in, output logic dac_bit);
    i_aud_bclk    = 1'b0;
    i_aud_adclrck = lr;
    i_aud_daclrck = lr;
    i_aud_adcdat  = bit_in;
    tick(4);
    i_aud_bclk = 1'b1;
    tick(4);
    dac_bit = o_aud_dacdat;
  endtask

  task automatic run_half(input logic lr, input logic [DW-1:0] word, input int s_lo, input int s_hi,
                          output logic [DW-1:0] dac_word, output logic rdy_l, output logic rdy_r);
    logic b;
    dac_word = '0;
    rdy_l = 1'b0;
    rdy_r = 1'b0;
    for (int s = s_lo; s <= s_hi; s++) begin
      slot(lr, (s >= 1 && s <= DW) ? word[DW-s] : 1'b0, b);
      if (s == 0) begin
        rdy_l = dac_left_ready;
        rdy_r = dac_right_ready;
      end
      if (s >= 1 && s <= DW) dac_word[DW-s] = b;
    end
  endtask

  task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           output logic [DW-1:0] dl, output logic [DW-1:0] dr,
                           output logic rl, output logic rr);
    logic x1, x2;
    run_half(1'b0, l, 0, 31, dl, rl, rr);
    run_half(1'b1, r, 0, 31, dr, x1, x2);
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    dac_left_data   = l;
    dac_right_data  = r;
    dac_left_valid  = 1'b1;
    dac_right_valid = 1'b1;
    tick(1);
    dac_left_valid  = 1'b0;
    dac_right_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    i_clr_status = 1'b1;
    tick(1);
    i_clr_status = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] dl, dr, hd;
    logic rl, rr, b;
    int lc0, rc0;

    // Reset
    i_rst = 1'b1;
    i_aud_bclk = 1'b0; i_aud_adclrck = 1'b1; i_aud_daclrck = 1'b1; i_aud_adcdat = 1'b0;
    adc_left_ready = 1'b1; adc_right_ready = 1'b1;
    dac_left_data = '0; dac_right_data = '0; dac_left_valid = 1'b0; dac_right_valid = 1'b0;
    i_clr_status = 1'b0;
`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
    i_loopback = 1'b0;
`endif
    tick(3);
    i_rst = 1'b0;
    check("rst_l_valid", 16'(adc_left_valid), 16'd0);
    check("rst_l_data", adc_left_data, 16'h0000);
    check("rst_r_valid", 16'(adc_right_valid), 16'd0);
    check("rst_r_data", adc_right_data, 16'h0000);
    check("rst_dl_ready", 16'(dac_left_ready), 16'd1);
    check("rst_dr_ready", 16'(dac_right_ready), 16'd1);
    check("rst_dacdat", 16'(o_aud_dacdat), 16'd0);
    check("rst_flags", {14'd0, o_adc_overrun, o_dac_underrun}, 16'd0);

    // Idle right-channel slots, then a basic frame with nothing pushed to the DAC
    for (int s = 0; s < 4; s++) slot(1'b1, 1'b0, b);
    run_frame(16'hA5C3, 16'h3C5A, dl, dr, rl, rr);
    check("adc_l_count", 16'(lcnt), 16'd1);
    check("adc_l_data", llast, 16'hA5C3);
    check("adc_r_count", 16'(rcnt), 16'd1);
    check("adc_r_data", rlast, 16'h3C5A);
    check("dac_l_empty_word", dl, 16'h0000);
    check("dac_r_empty_word", dr, 16'h0000);
    check("underrun_set", 16'(o_dac_underrun), 16'd1);
    check("overrun_clear", 16'(o_adc_overrun), 16'd0);
    clr_pulse();
    check("underrun_cleared", 16'(o_dac_underrun), 16'd0);

    // DAC words pushed ahead of the frame
    push(16'h8001, 16'h7FFE);
    check("dl_ready_full", 16'(dac_left_ready), 16'd0);
    check("dr_ready_full", 16'(dac_right_ready), 16'd0);
    run_frame(16'h1234, 16'h5678, dl, dr, rl, rr);
    check("dac_l_word", dl, 16'h8001);
    check("dac_r_word", dr, 16'h7FFE);
    check("dl_ready_at_load", 16'(rl), 16'd1);
    check("dr_ready_before_load", 16'(rr), 16'd0);
    check("dr_ready_after_load", 16'(dac_right_ready), 16'd1);
    check("no_underrun", 16'(o_dac_underrun), 16'd0);
    check("adc_l_data2", llast, 16'h1234);
    check("adc_r_data2", rlast, 16'h5678);

    // Left consumer stalled across two words
    adc_left_ready = 1'b0;
    lc0 = lcnt;
    run_frame(16'h1111, 16'h0000, dl, dr, rl, rr);
    check("stall_valid1", 16'(adc_left_valid), 16'd1);
    check("stall_data1", adc_left_data, 16'h1111);
    check("stall_no_overrun", 16'(o_adc_overrun), 16'd0);
    run_frame(16'h2222, 16'h0000, dl, dr, rl, rr);
    check("stall_valid2", 16'(adc_left_valid), 16'd1);
    check("stall_data2", adc_left_data, 16'h2222);
    check("overrun_set", 16'(o_adc_overrun), 16'd1);
    clr_pulse();
    check("overrun_cleared", 16'(o_adc_overrun), 16'd0);
    check("underrun_cleared2", 16'(o_dac_underrun), 16'd0);
    adc_left_ready = 1'b1;
    tick(3);
    check("stall_one_beat", 16'(lcnt - lc0), 16'd1);
    check("stall_beat_data", llast, 16'h2222);
    check("stall_valid_drop", 16'(adc_left_valid), 16'd0);

    // Reset in the middle of a left word
    run_half(1'b0, 16'hBEEF, 0, 8, hd, rl, rr);
    check("pre_reset_underrun", 16'(o_dac_underrun), 16'd1);
    i_rst = 1'b1;
    tick(3);
    i_rst = 1'b0;
    check("mid_rst_l_valid", 16'(adc_left_valid), 16'd0);
    check("mid_rst_l_data", adc_left_data, 16'h0000);
    check("mid_rst_dl_ready", 16'(dac_left_ready), 16'd1);
    check("mid_rst_underrun", 16'(o_dac_underrun), 16'd0);
    lc0 = lcnt;
    rc0 = rcnt;
    run_half(1'b0, 16'hBEEF, 9, 31, hd, rl, rr);
    run_half(1'b1, 16'h3C3C, 0, 31, hd, rl, rr);
    check("partial_word_dropped", 16'(lcnt - lc0), 16'd0);
    check("post_rst_r_count", 16'(rcnt - rc0), 16'd1);
    check("post_rst_r_data", rlast, 16'h3C3C);
    run_frame(16'hC001, 16'h0FF0, dl, dr, rl, rr);
    check("post_rst_l_count", 16'(lcnt - lc0), 16'd1);
    check("post_rst_l_data", llast, 16'hC001);
    check("post_rst_r_data2", rlast, 16'h0FF0);

`ifdef I2S_CODEC_BRIDGE_LOOPBACK_EN
    // Loopback: DAC slots replay the latest captured ADC samples
    clr_pulse();
    push(16'h5555, 16'hAAAA);
    i_loopback = 1'b1;
    run_frame(16'h0F0F, 16'h00F0, dl, dr, rl, rr);
    check("lb_l_prev_sample", dl, 16'hC001);
    run_frame(16'h0000, 16'h0000, dl, dr, rl, rr);
    check("lb_l_word", dl, 16'h0F0F);
    check("lb_r_word", dr, 16'h00F0);
    check("lb_no_underrun", 16'(o_dac_underrun), 16'd0);
    check("lb_sink_untouched", 16'(dac_left_ready), 16'd0);
    check("lb_adc_l_data", llast, 16'h0000);
    i_loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
